div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_if.sv | 23 ++
 rtl/div_unit.sv | 110 +++++++++++
 tb/tb_div_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Start/operand and result/status bundle between the control unit and div_unit.
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic                     DivCtrl;
  logic signed [DATA_W-1:0] A;
  logic signed [DATA_W-1:0] B;
  logic signed [DATA_W-1:0] HI;
  logic signed [DATA_W-1:0] LO;
  logic                     DivStop;
  logic                     DivZero;
  logic                     DivBusy;

  modport master (
    output DivCtrl, A, B,
    input  HI, LO, DivStop, DivZero, DivBusy
  );

  modport slave (
    input  DivCtrl, A, B,
    output HI, LO, DivStop, DivZero, DivBusy
  );
endinterface

// File: rtl/div_unit.sv
// Signed 32-bit restoring divider: one quotient bit per clock, then a sign-fixup
// cycle.
module div_unit #(
  parameter int DATA_W = 32
) (
  input logic       clk,
  input logic       reset,
  div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   mag_b_q;
  logic [DATA_W-1:0]   rem_q;
  logic [DATA_W-1:0]   quo_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic                sign_a_q;
  logic                sign_b_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                stop_q;
  logic                zero_q;
  logic                busy_q;

  logic [DATA_W:0]     trial_d;
  logic [DATA_W-1:0]   rem_d;
  logic [DATA_W-1:0]   quo_d;

  // Unsigned magnitude; the most negative value maps onto itself without overflow.
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v);
    logic [DATA_W-1:0] u;
    u = $unsigned(v);
    return u[DATA_W-1] ? (~u + DATA_W'(1)) : u;
  endfunction

  function automatic logic [DATA_W-1:0] negate_if(input logic neg,
                                                   input logic [DATA_W-1:0] v);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

  // quo_q starts as |A| and shifts out dividend bits while quotient bits shift in.
  always_comb begin
    trial_d = {rem_q, quo_q[DATA_W-1]} - {1'b0, mag_b_q};
    rem_d   = trial_d[DATA_W] ? {rem_q[DATA_W-2:0], quo_q[DATA_W-1]}
                              : trial_d[DATA_W-1:0];
    quo_d   = {quo_q[DATA_W-2:0], ~trial_d[DATA_W]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mag_b_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= '0;
      stop_q   <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      stop_q <= 1'b0;
      zero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.DivCtrl) begin
            if (bus.B == '0) begin
              zero_q <= 1'b1;
            end else begin
              mag_b_q  <= magnitude(bus.B);
              quo_q    <= magnitude(bus.A);
              sign_a_q <= bus.A[DATA_W-1];
              sign_b_q <= bus.B[DATA_W-1];
              rem_q    <= '0;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= RUN;
            end
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == '1) state_q <= FIX;
        end
        FIX: begin
          lo_q    <= negate_if(sign_a_q ^ sign_b_q, quo_q);
          hi_q    <= negate_if(sign_a_q, rem_q);
          stop_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;
  assign bus.DivStop = stop_q;
  assign bus.DivZero = zero_q;
  assign bus.DivBusy = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed corner cases plus random operands checked
// against 64-bit integer division.
module tb_div_unit;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  div_unit_if #(.DATA_W(32)) bus ();

  div_unit #(.DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  // MIPS DIV: truncating quotient, remainder takes the dividend's sign.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, q64, r64;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    q64 = sa / sb;
    r64 = sa % sb;
    q   = q64[31:0];
    r   = r64[31:0];
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
  endtask

  // Full division; with disturb, operands change after the start edge and a
  // stray start request arrives mid-run.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit disturb);
    logic [31:0] eq, er;
    int  lat;
    bit  seen, zseen;
    ref_div(a, b, eq, er);
    bus.DivCtrl = 1'b1;
    bus.A = a;
    bus.B = b;
    tick();
    bus.DivCtrl = 1'b0;
    if (disturb) begin
      bus.A = $urandom;
      bus.B = $urandom;
    end
    chk("busy_start", 32'(bus.DivBusy), 32'd1);
    lat = 0; seen = 0; zseen = 0;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      if (bus.DivZero) zseen = 1;
      if (bus.DivStop) seen = 1;
      else if (!bus.DivBusy) lat = 40;
      bus.DivCtrl = (disturb && lat == 5);
    end
    bus.DivCtrl = 1'b0;
    chk("latency", lat, 33);
    chk("LO", bus.LO, eq);
    chk("HI", bus.HI, er);
    chk("busy_end", 32'(bus.DivBusy), 32'd0);
    chk("no_zero", 32'(zseen), 32'd0);
    exp_lo = eq;
    exp_hi = er;
    tick();
    chk("stop_pulse", 32'(bus.DivStop), 32'd0);
  endtask

  task automatic run_zero(input logic [31:0] a);
    int stops;
    bus.DivCtrl = 1'b1;
    bus.A = a;
    bus.B = '0;
    tick();
    bus.DivCtrl = 1'b0;
    chk("zero_pulse", 32'(bus.DivZero), 32'd1);
    chk("zero_stop", 32'(bus.DivStop), 32'd0);
    chk("zero_busy", 32'(bus.DivBusy), 32'd0);
    tick();
    chk("zero_once", 32'(bus.DivZero), 32'd0);
    stops = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.DivStop) stops++;
      tick();
    end
    chk("zero_nostop", stops, 0);
    chk("zero_HI", bus.HI, exp_hi);
    chk("zero_LO", bus.LO, exp_lo);
  endtask

  initial begin
    logic [31:0] ra, rb, q1, r1, q2, r2;
    int stops, lat;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.DivCtrl = 1'b0;
    bus.A = '0;
    bus.B = '0;
    tick();
    do_reset();
    chk("rst_HI", bus.HI, 32'd0);
    chk("rst_LO", bus.LO, 32'd0);
    chk("rst_stop", 32'(bus.DivStop), 32'd0);
    chk("rst_zero", 32'(bus.DivZero), 32'd0);
    chk("rst_busy", 32'(bus.DivBusy), 32'd0);

    run_div(32'd7, 32'd2, 0);
    run_zero(32'd5);
    run_div(32'hFFFF_FFF9, 32'd2, 0);
    run_div(32'd7, 32'hFFFF_FFFE, 0);
    run_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, 0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div(32'h8000_0000, 32'd1, 0);
    run_div(32'h7FFF_FFFF, 32'h8000_0000, 0);
    run_div(32'd0, 32'd3, 0);

    // Reset in the middle of a run aborts it.
    bus.DivCtrl = 1'b1;
    bus.A = 32'd100;
    bus.B = 32'd7;
    tick();
    bus.DivCtrl = 1'b0;
    repeat (9) tick();
    do_reset();
    chk("abort_HI", bus.HI, 32'd0);
    chk("abort_LO", bus.LO, 32'd0);
    chk("abort_busy", 32'(bus.DivBusy), 32'd0);
    stops = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.DivStop) stops++;
      tick();
    end
    chk("abort_nostop", stops, 0);
    run_div(32'd100, 32'd7, 1);

    // Reset wins over a simultaneous start request.
    reset = 1'b1;
    bus.DivCtrl = 1'b1;
    bus.A = 32'd9;
    bus.B = 32'd3;
    tick();
    reset = 1'b0;
    bus.DivCtrl = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    chk("rst_ctrl_busy", 32'(bus.DivBusy), 32'd0);
    tick();
    chk("rst_ctrl_busy2", 32'(bus.DivBusy), 32'd0);

    // Back-to-back: DivCtrl held high across two operations.
    ref_div(32'd1000, 32'hFFFF_FFFD, q1, r1);
    ref_div(32'hFFFF_FC18, 32'd7, q2, r2);
    bus.DivCtrl = 1'b1;
    bus.A = 32'd1000;
    bus.B = 32'hFFFF_FFFD;
    tick();
    lat = 0;
    while (!bus.DivStop && lat < 40) begin
      tick();
      lat++;
    end
    chk("b2b_lat1", lat, 33);
    chk("b2b_LO1", bus.LO, q1);
    chk("b2b_HI1", bus.HI, r1);
    bus.A = 32'hFFFF_FC18;
    bus.B = 32'd7;
    lat = 0;
    tick();
    while (!bus.DivStop && lat < 40) begin
      bus.DivCtrl = 1'b0;
      tick();
      lat++;
    end
    bus.DivCtrl = 1'b0;
    chk("b2b_lat2", lat, 33);
    chk("b2b_LO2", bus.LO, q2);
    chk("b2b_HI2", bus.HI, r2);
    tick();

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 4))
        0: ra = 32'h8000_0000;
        1: ra = $urandom_range(0, 20) - 10;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: rb = 32'hFFFF_FFFF;
        1: rb = $urandom_range(0, 20) - 10;
        2: rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if (rb == 32'd0) run_zero(ra);
      else run_div(ra, rb, bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
